// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared FSM state encodings and default timing for the
// RTC multiplexed-bus master (also decoded by the top-level debug mux).
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_SETUP,
        ST_A_PULSE,
        ST_A_HOLD,
        ST_GAP,
        ST_D_SETUP,
        ST_D_PULSE,
        ST_D_HOLD,
        ST_DONE
    } state_e;

    localparam int T_SETUP_DEF = 2;
    localparam int T_PULSE_DEF = 10;
    localparam int T_HOLD_DEF  = 2;
    localparam int T_GAP_DEF   = 4;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// bus_phase_timer: loadable down-counter shared by every timed bus state.
// Ports: clk, reset_n, load (take value), value, expired (count is zero).
module bus_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = value;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: two-phase (address, gap, data) bus master for the RTC chip.
// Ports: start/we/addr/wdata request in; busy/done/rdata out; pin side
// cs_n/rd_n/wr_n/a_d/ad_out/ad_oe out, ad_in in. All pin outputs registered.
module rtc_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_PULSE = T_PULSE_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam int TMAX = max4(T_SETUP, T_PULSE, T_HOLD, T_GAP);
    localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] V_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] V_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] V_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] V_GAP   = CW'(T_GAP - 1);

    state_e        state_q;
    logic          we_q;
    logic [7:0]    wdata_q;
    logic          busy_q, done_q;
    logic [7:0]    rdata_q;
    logic          cs_n_q, rd_n_q, wr_n_q, a_d_q, ad_oe_q;
    logic [7:0]    ad_out_q;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_exp;

    // Reload the timer on every state change with the next state's length.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin tmr_load = start;   tmr_val = V_SETUP; end
            ST_A_SETUP:       begin tmr_load = tmr_exp; tmr_val = V_PULSE; end
            ST_A_PULSE:       begin tmr_load = tmr_exp; tmr_val = V_HOLD;  end
            ST_A_HOLD:        begin tmr_load = tmr_exp; tmr_val = V_GAP;   end
            ST_GAP:           begin tmr_load = tmr_exp; tmr_val = V_SETUP; end
            ST_D_SETUP:       begin tmr_load = tmr_exp; tmr_val = V_PULSE; end
            ST_D_PULSE:       begin tmr_load = tmr_exp; tmr_val = V_HOLD;  end
            default: ;
        endcase
    end

    bus_phase_timer #(.W(CW)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_val),
        .expired (tmr_exp)
    );

    // Outputs are set on the transition into each state so pins are
    // registered and change exactly when the state does.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            wdata_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 8'h00;
            cs_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= 8'h00;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_A_SETUP;
                        we_q     <= we;
                        wdata_q  <= wdata;
                        busy_q   <= 1'b1;
                        cs_n_q   <= 1'b0;
                        a_d_q    <= 1'b0;
                        ad_oe_q  <= 1'b1;
                        ad_out_q <= addr;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_A_SETUP: if (tmr_exp) begin
                    state_q <= ST_A_PULSE;
                    wr_n_q  <= 1'b0;
                end
                ST_A_PULSE: if (tmr_exp) begin
                    state_q <= ST_A_HOLD;
                    wr_n_q  <= 1'b1;
                end
                ST_A_HOLD: if (tmr_exp) begin
                    state_q <= ST_GAP;
                    cs_n_q  <= 1'b1;
                    ad_oe_q <= 1'b0;
                    a_d_q   <= 1'b1;
                end
                ST_GAP: if (tmr_exp) begin
                    state_q <= ST_D_SETUP;
                    cs_n_q  <= 1'b0;
                    ad_oe_q <= we_q;
                    if (we_q)
                        ad_out_q <= wdata_q;
                end
                ST_D_SETUP: if (tmr_exp) begin
                    state_q <= ST_D_PULSE;
                    wr_n_q  <= ~we_q;
                    rd_n_q  <= we_q;
                end
                ST_D_PULSE: if (tmr_exp) begin
                    state_q <= ST_D_HOLD;
                    wr_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                    if (!we_q)
                        rdata_q <= ad_in;
                end
                ST_D_HOLD: if (tmr_exp) begin
                    state_q <= ST_DONE;
                    cs_n_q  <= 1'b1;
                    ad_oe_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign rdata  = rdata_q;
    assign cs_n   = cs_n_q;
    assign rd_n   = rd_n_q;
    assign wr_n   = wr_n_q;
    assign a_d    = a_d_q;
    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;

endmodule

// File: doc/rtc_bus_ctrl.md
# rtc_bus_ctrl

Bus master for the real-time-clock chip's multiplexed address/data interface. Takes one register-access request (register address as produced by the port-ID decoder's RTC address output, read/write flag, write data) from the processor-side glue. Runs the two-phase external cycle: address phase, inter-phase gap, data phase. Returns read data with a one-cycle done pulse. Sits between the port decoding logic and the RTC chip pins.

## Interface
- `T_SETUP`, default 2: cycles `cs_n` and `a_d` are stable with the bus driven before the strobe falls. Must be ≥1.
- `T_PULSE`, default 10: cycles `wr_n`/`rd_n` stay low. Must be ≥1.
- `T_HOLD`, default 2: cycles after the strobe rises with `cs_n` still low and the bus held. Must be ≥1.
- `T_GAP`, default 4: cycles `cs_n` is high between the address and data phases. Must be ≥1.
- `clk` input 1: system clock, 100 MHz.
- `reset_n` input 1: **one clock; reset is asynchronous and active-low.**
- `start` input 1: request strobe; sampled only when `busy`=0.
- `we` input 1: 1 = write, 0 = read; sampled with `start`.
- `addr` input 8: RTC register address; sampled with `start`.
- `wdata` input 8: write data; sampled with `start`.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle completion pulse.
- `rdata` output 8: last read result.
- `cs_n`, `rd_n`, `wr_n` output 1 each: chip select and strobes, all active-low.
- `a_d` output 1: 0 = address phase, 1 = data phase.
- `ad_out` output 8: value driven onto the pad bus.
- `ad_oe` output 1: pad output enable.
- `ad_in` input 8: value read from the pad bus.

## Operation
- FSM states: IDLE → A_SETUP → A_PULSE → A_HOLD → GAP → D_SETUP → D_PULSE → D_HOLD → DONE → IDLE.
- Each timed state lasts exactly its parameter's number of cycles. DONE lasts 1 cycle.
- A request latches `we`, `addr` and `wdata` into internal registers. Input changes after acceptance have no effect.
- Address phase (A_*):
  - `a_d`=0, `ad_out`=latched `addr`, `ad_oe`=1, `cs_n`=0.
  - `wr_n`=0 only in A_PULSE. This applies to both reads and writes.
- GAP: `cs_n`=1, `ad_oe`=0, `a_d`=1, strobes high.
- Data phase, write:
  - `a_d`=1, `cs_n`=0, `ad_oe`=1, `ad_out`=latched `wdata`.
  - `wr_n`=0 only in D_PULSE.
- Data phase, read:
  - `a_d`=1, `cs_n`=0, `ad_oe`=0.
  - `rd_n`=0 only in D_PULSE.
  - `rdata` loads `ad_in` on the clock edge that ends the last D_PULSE cycle.
- `rdata` holds its value until the next read completes. Writes never change it.
- `rd_n` and `wr_n` are never low simultaneously.
- `ad_oe` is never 1 while `rd_n`=0.
- All pin outputs are registered (glitch-free).

## Timing
- Reset values:
  - `cs_n`=1, `rd_n`=1, `wr_n`=1, `a_d`=1.
  - `ad_oe`=0, `ad_out`=0x00.
  - `busy`=0, `done`=0, `rdata`=0x00.
  - State = IDLE.
- `start` sampled high at edge k (`busy`=0) → A_SETUP is visible in cycle k+1.
- With default parameters:
  - A_PULSE: k+3..k+12.
  - GAP: k+15..k+18.
  - D_PULSE: k+21..k+30.
  - `rdata` valid from k+31.
  - `done`=1 in cycle k+33.
- General latency from acceptance to `done`: 2·(T_SETUP+T_PULSE+T_HOLD)+T_GAP+1 cycles.
- `busy`=1 from k+1 through the last D_HOLD cycle. `busy`=0 in the DONE cycle.
- `start` during `busy`=1 is ignored, not queued.
- `start` in the DONE cycle is accepted: back-to-back operation, and A_SETUP follows immediately.
- `reset_n` low at any time:
  - All outputs go to their reset values immediately.
  - No `done` is issued. The transaction is lost.
- Timing counter width is wide enough for the largest parameter value; each state loads its parameter−1 and exits when the counter reaches 0.

## Structure
- Shared package `rtc_bus_pkg`: FSM state encodings and default timing constants. The state encodings are shared so the top-level debug mux can decode the state.
- One sub-module: `bus_phase_timer`, a loadable down-counter with a `load` input, a `value` input and an `expired` output, reused for every timed state.

## Test plan
- Write `addr`=0x21, `wdata`=0x45 → two `wr_n` pulses of 10 cycles each, with `ad_out`=0x21 (`a_d`=0) then 0x45 (`a_d`=1); `done` at k+33; `rdata` unchanged.
- Read `addr`=0x41 with the bus model returning 0x17 only while `rd_n`=0 → `ad_oe`=0 throughout the data phase; `rdata`=0x17 from k+31; `done` at k+33.
- `start` pulsed at k+5 during a write → ignored; exactly one `done` is issued and the latched request data is unchanged.
- `reset_n` low during A_PULSE → `wr_n`, `cs_n` and `ad_oe` revert to their reset values with no clock edge; no `done`; a new request after reset completes normally.
- `start` held high continuously with alternating write/read → second A_SETUP starts the cycle after `done`; no idle cycle between transactions.
- Parameters `T_SETUP`=`T_PULSE`=`T_HOLD`=`T_GAP`=1 → latency is 8 cycles and each strobe is exactly 1 cycle wide.
